ysyx_23060201_ifu_fq: RTL and testbench
=======================================

# ysyx_23060201_ifu_fq

Parametrised instruction fetch unit with a valid/ready memory request/response interface and an in-order fetch queue of `FQ_DEPTH` entries. It sits between the instruction memory port and the IDU. It keeps fetching sequential PCs ahead of decode, and handles backend redirects by flushing the queue and discarding any stale in-flight response.

## Interface
- `ADDR_WIDTH`, 32, PC and memory address width.
- `DATA_WIDTH`, 32, instruction width.
- `FQ_DEPTH`, 4, fetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `redirect_valid` in 1: backend redirect (taken jump/branch/trap) this cycle.
- `redirect_pc` in ADDR_WIDTH: redirect target.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_WIDTH: fetch address.
- `mem_rsp_valid` in 1: response valid; always accepted, no ready.
- `mem_rsp_data` in DATA_WIDTH: fetched instruction.
- `out_valid` out 1: queue head valid toward the IDU.
- `out_ready` in 1: IDU accepts the head.
- `out_pc` out ADDR_WIDTH: PC of the head entry.
- `out_inst` out DATA_WIDTH: instruction of the head entry.
- `out_fault` out 1: head entry is a misaligned-fetch fault.

## Operation
- Registers:
  - `fpc`: next fetch PC.
  - FSM state.
  - `drop` flag.
  - Circular queue with rd/wr pointers of `$clog2(FQ_DEPTH)+1` bits; the MSB is the wrap bit.
  - full = low bits equal and wrap bits differ; empty = pointers equal.
- FSM states: IDLE, REQ, WAIT (plus HALT when `IFU_ALIGN_CHK_EN` is defined).
- IDLE:
  - Move to REQ when count < FQ_DEPTH.
  - At most one request is outstanding, so that request always has a reserved slot.
- REQ:
  - `mem_req_valid`=1 and `mem_req_addr`=`fpc`.
  - Addr stays stable until accepted.
  - On `mem_req_ready`, latch the request PC into `req_pc`, set `fpc`←`fpc`+4 (mod 2^ADDR_WIDTH, wraps silently), and move to WAIT.
- WAIT:
  - On `mem_rsp_valid` with `drop`=0, push {`req_pc`, `mem_rsp_data`, fault=0}.
  - On `mem_rsp_valid` with `drop`=1, discard the response and clear `drop`.
  - Next state is REQ if the post-push count (including any same-cycle pop) < FQ_DEPTH, else IDLE.
- Pop: `out_valid` = !empty && !`redirect_valid`. A pop occurs on `out_valid`&&`out_ready`.
- Redirect (highest priority):
  - Queue is flushed (rd←wr); `fpc`←`redirect_pc`.
  - Any same-cycle push is suppressed.
  - In REQ: the held request still completes, then `drop` is set at acceptance.
  - In WAIT without a response this cycle: `drop`←1.
  - In WAIT with a response this cycle: the response is discarded, `drop` stays 0.
  - Back-to-back redirects: the last one wins; `drop` stays set until the single outstanding response returns.
- Simultaneous push and pop when the queue has count=FQ_DEPTH-1 is legal; count is unchanged. Push into a full queue is impossible by construction.

## Timing
- Reset values:
  - `fpc`=RESET_PC, state=REQ, queue empty, `drop`=0.
  - `mem_req_valid`=1 and `mem_req_addr`=RESET_PC, present immediately during and after reset.
  - `out_valid`=0; `out_pc`, `out_inst`, `out_fault` = 0.
- Request accepted in cycle N → earliest response in N+1 → `out_valid` in the cycle after the response (registered queue).
- Response → next `mem_req_valid` in the next cycle if space exists. Steady-state throughput is one instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N:
  - `out_valid`=0 in cycle N.
  - Queue is empty from N+1.
  - `mem_req_addr`=`redirect_pc` from N+1 once the FSM reaches REQ.
- Reset asserted mid-transaction: all state is cleared asynchronously. The memory side must also be reset; a response arriving after reset release without a request is ignored.

## Configuration
- `IFU_ALIGN_CHK_EN`
  - Defined:
    - A redirect with `redirect_pc[1:0]`≠0 loads `fpc` and enters HALT; no memory request is issued.
    - In HALT the block pushes one entry {`redirect_pc`, inst=0, fault=1} once space exists (the queue is empty after the flush, so the push happens the next cycle), then stays in HALT.
    - HALT exits only on the next redirect.
  - Undefined: `redirect_pc[1:0]` is forced to 2'b00, HALT does not exist, and `out_fault` is tied to 0.

## Test plan
- Reset release, memory always ready with 1-cycle response: `out_pc` sequence is 0x80000000, 0x80000004, 0x80000008… with matching `mem_rsp_data`.
- `out_ready`=0 for 20 cycles (FQ_DEPTH=4): exactly 4 entries are queued, `mem_req_valid` deasserts, no overflow. Releasing `out_ready` drains them in order.
- Redirect to 0x80000100 while in WAIT: the stale response is discarded, the queue is empty, and the next `out_pc` is 0x80000100.
- Redirect during REQ with `mem_req_ready` held low 3 cycles: `mem_req_addr` stays stable until accepted, that response is dropped, and the following request uses 0x80000100.
- Push/pop together at count=3: count stays 3 and ordering is preserved across pointer wrap.
- With `IFU_ALIGN_CHK_EN` defined, redirect to 0x80000102: one entry {0x80000102, 0, fault=1} is produced, and no `mem_req_valid` until a redirect to 0x80000200.

Source files
------------

// File: rtl/ysyx_23060201_ifu_fq.sv
// Instruction fetch unit: one-outstanding valid/ready memory port feeding an in-order fetch queue.
// Define IFU_ALIGN_CHK_EN to turn misaligned redirect targets into a queued fetch fault (HALT state).
module ysyx_23060201_ifu_fq #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_fault
);

  localparam int IDX_W = $clog2(FQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FQ_DEPTH);

`ifdef IFU_ALIGN_CHK_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
`endif

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_fpc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic [ADDR_WIDTH-1:0] r_rpc;
  logic                  r_drop;
  logic                  r_rpend;
  logic [PTR_W-1:0]      r_rd;
  logic [PTR_W-1:0]      r_wr;
  logic [ADDR_WIDTH-1:0] r_pc_q   [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_inst_q [FQ_DEPTH];

  logic [PTR_W-1:0]      w_cnt;
  logic [PTR_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_fire;
  logic                  w_rsp_push;
  logic                  w_halt_push;
  logic                  w_push;
  logic                  w_tgt_redir;
  logic [ADDR_WIDTH-1:0] w_rpc;
  logic [ADDR_WIDTH-1:0] w_tgt;
  logic [ADDR_WIDTH-1:0] w_push_pc;
  logic [DATA_WIDTH-1:0] w_push_inst;
  state_t                w_redir_st;
  state_t                w_fire_st;

  assign w_rd_idx  = r_rd[IDX_W-1:0];
  assign w_wr_idx  = r_wr[IDX_W-1:0];
  assign w_cnt     = r_wr - r_rd;
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr[IDX_W] != r_rd[IDX_W]);

  // While a stale response is still owed (drop set outside WAIT) no new request is issued,
  // which keeps the memory at one outstanding transaction.
  assign mem_req_valid = (r_state == S_REQ) && !r_drop;
  assign mem_req_addr  = r_fpc;
  assign w_fire        = mem_req_valid && mem_req_ready;

  assign out_valid  = !w_empty && !redirect_valid;
  assign w_pop      = out_valid && out_ready;
  assign w_rsp_push = (r_state == S_WAIT) && mem_rsp_valid && !r_drop && !redirect_valid;
  assign w_push     = w_rsp_push || w_halt_push;
  assign w_cnt_nxt  = w_cnt + PTR_W'(w_push) - PTR_W'(w_pop);

  assign w_tgt_redir = redirect_valid || r_rpend;
  assign w_tgt       = redirect_valid ? w_rpc : r_rpc;

  assign out_pc   = w_empty ? '0 : r_pc_q[w_rd_idx];
  assign out_inst = w_empty ? '0 : r_inst_q[w_rd_idx];

`ifdef IFU_ALIGN_CHK_EN
  logic r_hdone;
  logic r_flt_q [FQ_DEPTH];

  assign w_rpc       = redirect_pc;
  assign w_redir_st  = (|redirect_pc[1:0]) ? S_HALT : S_REQ;
  assign w_fire_st   = (|w_tgt[1:0]) ? S_HALT : S_WAIT;
  assign w_halt_push = (r_state == S_HALT) && !r_hdone && !w_full && !redirect_valid;
  assign w_push_pc   = w_halt_push ? r_fpc : r_req_pc;
  assign w_push_inst = w_halt_push ? '0 : mem_rsp_data;
  assign out_fault   = !w_empty && r_flt_q[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdone <= 1'b0;
    end else if (redirect_valid || (w_fire && w_tgt_redir)) begin
      r_hdone <= 1'b0;
    end else if (w_halt_push) begin
      r_hdone <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_flt_q[w_wr_idx] <= w_halt_push;
  end
`else
  logic w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_rpc        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_redir_st   = S_REQ;
  assign w_fire_st    = S_WAIT;
  assign w_halt_push  = 1'b0;
  assign w_push_pc    = r_req_pc;
  assign w_push_inst  = mem_rsp_data;
  assign out_fault    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_fpc   <= RESET_PC;
      r_drop  <= 1'b0;
      r_rpend <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      if (redirect_valid)  r_rd <= r_wr;
      else if (w_pop)      r_rd <= r_rd + PTR_W'(1);
      if (w_push)          r_wr <= r_wr + PTR_W'(1);
      if (mem_rsp_valid)   r_drop <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_fpc   <= w_rpc;
            r_state <= w_redir_st;
          end else if (w_cnt < DEPTH_P) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_fire) begin
            // A redirect seen while the request was held retires it as a stale fetch.
            r_rpend <= 1'b0;
            r_state <= w_tgt_redir ? w_fire_st : S_WAIT;
            r_fpc   <= w_tgt_redir ? w_tgt : r_fpc + ADDR_WIDTH'(4);
            if (w_tgt_redir) r_drop <= 1'b1;
          end else if (redirect_valid) begin
            if (mem_req_valid) begin
              r_rpend <= 1'b1;
            end else begin
              r_fpc   <= w_rpc;
              r_state <= w_redir_st;
            end
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (redirect_valid) begin
              r_fpc   <= w_rpc;
              r_state <= w_redir_st;
            end else begin
              r_state <= (w_cnt_nxt < DEPTH_P) ? S_REQ : S_IDLE;
            end
          end else if (redirect_valid) begin
            r_fpc  <= w_rpc;
            r_drop <= 1'b1;
            if (w_redir_st != S_REQ) r_state <= w_redir_st;
          end
        end
`ifdef IFU_ALIGN_CHK_EN
        S_HALT: begin
          if (redirect_valid) begin
            r_fpc   <= w_rpc;
            r_state <= w_redir_st;
          end
        end
`endif
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire)         r_req_pc <= r_fpc;
    if (redirect_valid) r_rpc    <= w_rpc;
    if (w_push) begin
      r_pc_q[w_wr_idx]   <= w_push_pc;
      r_inst_q[w_wr_idx] <= w_push_inst;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_ifu_fq.sv
// Directed bench for ysyx_23060201_ifu_fq: a 1-cycle memory responder lives inside the tick task.
module tb_ysyx_23060201_ifu_fq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          auto_rsp;
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];

  always #5 clk = ~clk;

  ysyx_23060201_ifu_fq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, answer an accepted request the next cycle.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    #1;
    fire = mem_req_valid && mem_req_ready;
    a    = mem_req_addr;
    if (out_valid && out_ready) begin
      log_pc.push_back(out_pc);
      log_inst.push_back(out_inst);
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = auto_rsp && fire;
    mem_rsp_data  = inst_of(a);
  endtask

  initial begin
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    out_ready      = 1'b0;
    auto_rsp       = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_vld",  mem_req_valid, 1);
    chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
    chk("rst_out_vld",  out_valid, 0);
    chk("rst_out_pc",   out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_flt",  out_fault, 0);

    // Sequential fetch with an always-ready memory and consumer.
    rst_n         = 1'b1;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    auto_rsp      = 1'b1;
    repeat (8) tick();
    chk("seq_npop",  log_pc.size(), 3);
    chk("seq_pc0",   log_pc[0], 32'h8000_0000);
    chk("seq_inst0", log_inst[0], 32'h0000_0013);
    chk("seq_pc1",   log_pc[1], 32'h8000_0004);
    chk("seq_inst1", log_inst[1], 32'h0004_0013);
    chk("seq_pc2",   log_pc[2], 32'h8000_0008);
    chk("seq_inst2", log_inst[2], 32'h0008_0013);
    chk("seq_head",  out_pc, 32'h8000_000C);
    chk("seq_addr",  mem_req_addr, 32'h8000_0010);

    // Stalled consumer: the queue fills to four and requests stop.
    out_ready = 1'b0;
    repeat (20) tick();
    chk("full_req_vld", mem_req_valid, 0);
    chk("full_out_vld", out_valid, 1);
    chk("full_head",    out_pc, 32'h8000_000C);
    chk("full_npop",    log_pc.size(), 3);

    mem_req_ready = 1'b0;
    out_ready     = 1'b1;
    log_pc.delete();
    log_inst.delete();
    repeat (12) tick();
    chk("drain_npop",  log_pc.size(), 4);
    chk("drain_pc0",   log_pc[0], 32'h8000_000C);
    chk("drain_pc1",   log_pc[1], 32'h8000_0010);
    chk("drain_pc2",   log_pc[2], 32'h8000_0014);
    chk("drain_pc3",   log_pc[3], 32'h8000_0018);
    chk("drain_inst3", log_inst[3], 32'h0018_0013);
    chk("drain_vld",   out_valid, 0);
    chk("drain_req",   mem_req_valid, 1);
    chk("drain_addr",  mem_req_addr, 32'h8000_001C);

    // Redirect while a request is held by a busy memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("hold_vld",  mem_req_valid, 1);
    chk("hold_addr", mem_req_addr, 32'h8000_001C);
    mem_req_ready = 1'b1;
    tick();
    tick();
    chk("rreq_vld",   mem_req_valid, 1);
    chk("rreq_addr",  mem_req_addr, 32'h8000_0100);
    chk("rreq_empty", out_valid, 0);
    tick();
    tick();
    chk("rreq_pc",   out_pc, 32'h8000_0100);
    chk("rreq_inst", out_inst, 32'h0100_0013);

    // Redirect while waiting for a late response, with an entry queued.
    out_ready = 1'b0;
    auto_rsp  = 1'b0;
    tick();
    chk("wait_vld", out_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    #1;
    chk("wait_mask", out_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wait_flush", out_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    chk("wait_stale", out_valid, 0);
    chk("wait_addr",  mem_req_addr, 32'h8000_0200);
    auto_rsp  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("wait_pc",   out_pc, 32'h8000_0200);
    chk("wait_inst", out_inst, 32'h0200_0013);

    // Fill to three, then push and pop in the same cycle.
    out_ready = 1'b0;
    repeat (5) tick();
    chk("c3_head", out_pc, 32'h8000_0200);
    out_ready = 1'b1;
    log_pc.delete();
    log_inst.delete();
    tick();
    chk("c3_head2", out_pc, 32'h8000_0204);
    chk("c3_req",   mem_req_valid, 1);
    chk("c3_addr",  mem_req_addr, 32'h8000_0210);
    repeat (6) tick();
    chk("c3_npop",  log_pc.size(), 6);
    chk("c3_pc0",   log_pc[0], 32'h8000_0200);
    chk("c3_pc3",   log_pc[3], 32'h8000_020C);
    chk("c3_pc5",   log_pc[5], 32'h8000_0214);
    chk("c3_inst5", log_inst[5], 32'h0214_0013);

    // Misaligned redirect target, taken in the same cycle the request is accepted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_vld0", out_valid, 0);
`ifdef IFU_ALIGN_CHK_EN
    chk("halt_noreq", mem_req_valid, 0);
    out_ready = 1'b0;
    tick();
    chk("halt_vld",  out_valid, 1);
    chk("halt_pc",   out_pc, 32'h8000_0102);
    chk("halt_inst", out_inst, 0);
    chk("halt_flt",  out_fault, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("halt_empty",  out_valid, 0);
    chk("halt_noreq2", mem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("halt_exit_vld",  mem_req_valid, 1);
    chk("halt_exit_addr", mem_req_addr, 32'h8000_0200);
`else
    tick();
    chk("mis_addr", mem_req_addr, 32'h8000_0100);
    tick();
    tick();
    chk("mis_pc",  out_pc, 32'h8000_0100);
    chk("mis_flt", out_fault, 0);
`endif

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    chk("arst_req_vld",  mem_req_valid, 1);
    chk("arst_req_addr", mem_req_addr, 32'h8000_0000);
    chk("arst_out_vld",  out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
